// File: rtl/io_map_pkg.sv
`default_nettype none
// ============================================================================
//  io_map
//  IO address map and debounce FSM encoding, shared with the memory/IO router.
//  Revision: 1.0
// ============================================================================
package io_map;

   localparam logic [31:0] LED_LO_ADDR = 32'hFFFF_FC60;
   localparam logic [31:0] LED_HI_ADDR = 32'hFFFF_FC62;
   localparam logic [31:0] SW_LO_ADDR  = 32'hFFFF_FC70;
   localparam logic [31:0] SW_HI_ADDR  = 32'hFFFF_FC72;
   localparam logic [31:0] BTN_ADDR    = 32'hFFFF_FC74;

   typedef enum logic [0:0] {
      DB_STABLE   = 1'b0,
      DB_SETTLING = 1'b1
   } db_state_t;

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
//  io_debounce
//  Two-flop synchroniser followed by a counter-based debounce FSM.
//  Revision: 1.0
// ============================================================================
module io_debounce
   import io_map::*;
#(
   parameter int          WIDTH           = 1,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000,
   parameter int          CNT_W           = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] db,
   output logic [WIDTH-1:0] rise
);

   // The entry cycle into SETTLING already holds the first matching sample,
   // so committing at DEBOUNCE_CYCLES-2 gives exactly DEBOUNCE_CYCLES samples.
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 20'd2);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_db;
   logic [WIDTH-1:0] w_cand_nxt;
   logic [WIDTH-1:0] w_db_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic             w_commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pin;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= DB_STABLE;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_db    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_db_nxt    = r_db;
      w_commit    = 1'b0;
      case (r_state)
         DB_STABLE: begin
            if (r_sync2 != r_db) begin
               w_cand_nxt  = r_sync2;
               w_cnt_nxt   = '0;
               w_state_nxt = DB_SETTLING;
            end
         end
         DB_SETTLING: begin
            if (r_sync2 == r_db) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DB_STABLE;
            end else if (r_sync2 != r_cand) begin
               w_cand_nxt = r_sync2;
               w_cnt_nxt  = '0;
            end else if (r_cnt == c_cnt_last) begin
               w_commit    = 1'b1;
               w_db_nxt    = r_cand;
               w_cnt_nxt   = '0;
               w_state_nxt = DB_STABLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = DB_STABLE;
      endcase
   end

   assign db   = r_db;
   assign rise = {WIDTH{w_commit}} & r_cand & ~r_db;

endmodule
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
//  io_responder
//  IO-side responder: LED register, debounced switches, sticky button flag.
//  Revision: 1.0
// ============================================================================
module io_responder
   import io_map::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000,
   parameter int          CNT_W           = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_read,
   input  logic        io_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [15:0] io_rdata,
   input  logic [23:0] sw_pin,
   input  logic        btn_pin,
   output logic [23:0] led_pin
);

   logic [23:0] r_led;
   logic        r_btn_flag;
   logic [23:0] w_sw_db;
   logic [23:0] w_unused_sw_rise;
   logic        w_unused_btn_db;
   logic        w_btn_rise;
   logic [15:0] w_unused_wdata_hi;

   assign w_unused_wdata_hi = wdata[31:16];

   io_debounce #(
      .WIDTH           (24),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_sw_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin  (sw_pin),
      .db   (w_sw_db),
      .rise (w_unused_sw_rise)
   );

   io_debounce #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin  (btn_pin),
      .db   (w_unused_btn_db),
      .rise (w_btn_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led <= '0;
      end else if (io_write) begin
         if (addr == LED_LO_ADDR) begin
            r_led[15:0] <= wdata[15:0];
         end else if (addr == LED_HI_ADDR) begin
            r_led[23:16] <= wdata[7:0];
         end
      end
   end

   // A new press outranks a clearing read landing on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_flag <= 1'b0;
      end else if (w_btn_rise) begin
         r_btn_flag <= 1'b1;
      end else if (io_read && (addr == BTN_ADDR)) begin
         r_btn_flag <= 1'b0;
      end
   end

   always_comb begin
      io_rdata = 16'h0000;
      if (io_read) begin
         case (addr)
            LED_LO_ADDR: io_rdata = r_led[15:0];
            LED_HI_ADDR: io_rdata = {8'h00, r_led[23:16]};
            SW_LO_ADDR:  io_rdata = w_sw_db[15:0];
            SW_HI_ADDR:  io_rdata = {8'h00, w_sw_db[23:16]};
            BTN_ADDR:    io_rdata = {15'h0000, r_btn_flag};
            default:     io_rdata = 16'h0000;
         endcase
      end
   end

   assign led_pin = r_led;

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// ============================================================================
//  tb_io_responder
//  Randomised scoreboard bench for io_responder with a run-length debounce model.
//  Revision: 1.0
// ============================================================================
module tb_io_responder;
   import io_map::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_read = 1'b0;
   logic        io_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [15:0] io_rdata;
   logic [23:0] sw_pin = '0;
   logic        btn_pin = 1'b0;
   logic [23:0] led_pin;

   io_responder #(
      .DEBOUNCE_CYCLES (20'd8),
      .CNT_W           (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .io_read  (io_read),
      .io_write (io_write),
      .addr     (addr),
      .wdata    (wdata),
      .io_rdata (io_rdata),
      .sw_pin   (sw_pin),
      .btn_pin  (btn_pin),
      .led_pin  (led_pin)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] led;
      logic [15:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;

   logic [23:0] sw_val = '0;
   logic        btn_val = 1'b0;

   // Reference model: pins reach the debouncer two edges late; a value is
   // committed once the synchronised sample has held it for D cycles.
   logic [23:0] m_led;
   logic [23:0] m_sw_s1, m_sw_s2, m_sw_db;
   int          m_sw_run;
   logic        m_btn_s1, m_btn_s2, m_btn_db;
   int          m_btn_run;
   logic        m_flag;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = '0;
      m_sw_s1 = '0; m_sw_s2 = '0; m_sw_db = '0; m_sw_run = 1;
      m_btn_s1 = 1'b0; m_btn_s2 = 1'b0; m_btn_db = 1'b0; m_btn_run = 1;
      m_flag = 1'b0;
   endtask

   function automatic logic [15:0] model_read(input logic [31:0] a);
      if (a == LED_LO_ADDR)      return m_led[15:0];
      else if (a == LED_HI_ADDR) return {8'h00, m_led[23:16]};
      else if (a == SW_LO_ADDR)  return m_sw_db[15:0];
      else if (a == SW_HI_ADDR)  return {8'h00, m_sw_db[23:16]};
      else if (a == BTN_ADDR)    return {15'h0000, m_flag};
      return 16'h0000;
   endfunction

   function automatic logic btn_commit_now();
      return (m_btn_run >= D) && m_btn_s2 && !m_btn_db;
   endfunction

   task automatic model_edge(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [23:0] swp, input logic btnp);
      if (wr && a == LED_LO_ADDR) m_led[15:0] = wd[15:0];
      else if (wr && a == LED_HI_ADDR) m_led[23:16] = wd[7:0];
      if (btn_commit_now()) m_flag = 1'b1;
      else if (rd && a == BTN_ADDR) m_flag = 1'b0;
      if (m_sw_run >= D && m_sw_s2 != m_sw_db) m_sw_db = m_sw_s2;
      if (m_btn_run >= D && m_btn_s2 != m_btn_db) m_btn_db = m_btn_s2;
      m_sw_run  = (m_sw_s1 == m_sw_s2) ? ((m_sw_run < 1000) ? m_sw_run + 1 : m_sw_run) : 1;
      m_btn_run = (m_btn_s1 == m_btn_s2) ? ((m_btn_run < 1000) ? m_btn_run + 1 : m_btn_run) : 1;
      m_sw_s2 = m_sw_s1;   m_sw_s1 = swp;
      m_btn_s2 = m_btn_s1; m_btn_s1 = btnp;
   endtask

   task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      @(negedge clk);
      io_read = rd; io_write = wr; addr = a; wdata = wd;
      sw_pin = sw_val; btn_pin = btn_val;
      e.led = m_led;
      e.rdata = rd ? model_read(a) : 16'h0000;
      exp_q.push_back(e);
      mon_en = 1'b1;
      model_edge(rd, wr, a, wd, sw_val, btn_val);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0; io_read = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
      sw_pin = sw_val; btn_pin = btn_val;
      model_reset();
      model_edge(1'b0, 1'b0, 32'h0, 32'h0, sw_val, btn_val);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1; io_read = 1'b1; io_write = 1'b0; addr = LED_LO_ADDR;
      #1;
      chk("rst_led_pin", led_pin, 32'h0);
      chk("rst_rdata_led", io_rdata, 32'h0);
      addr = BTN_ADDR;
      #1;
      chk("rst_btn_flag", io_rdata, 32'h0);
      release_reset();
   endtask

   // Monitor: pops one expectation per active cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && !rst) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL scoreboard_empty: got none want entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_led_pin", led_pin, e.led);
               chk("sb_io_rdata", io_rdata, e.rdata);
            end
         end
      end
   end

   logic [31:0] addrs [9] = '{LED_LO_ADDR, LED_HI_ADDR, SW_LO_ADDR, SW_HI_ADDR, BTN_ADDR,
                              32'hFFFF_FC64, 32'hFFFF_FC61, 32'h0000_FC60, 32'hFFFF_FC76};

   initial begin
      int sw_hold, btn_hold, op;
      logic found;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("reset_led_pin", led_pin, 32'h0);
      chk("reset_io_rdata", io_rdata, 32'h0);
      release_reset();
      idle(2);

      // LED writes
      cycle(1'b0, 1'b1, LED_LO_ADDR, 32'hDEADBEEF);
      @(posedge clk); #1; chk("led_lo_write", led_pin, 32'h00BEEF);
      cycle(1'b0, 1'b1, LED_HI_ADDR, 32'h12345678);
      @(posedge clk); #1; chk("led_hi_write", led_pin, 32'h78BEEF);
      cycle(1'b0, 1'b1, 32'hFFFF_FC64, 32'hFFFFFFFF);
      @(posedge clk); #1; chk("led_unmapped_write", led_pin, 32'h78BEEF);

      // Switch debounce latency: cycle 0 is the first cycle the pins show the value
      sw_val = 24'hA5C3F0;
      for (int k = 0; k < 13; k++) begin
         cycle(1'b1, 1'b0, SW_LO_ADDR, 32'h0);
         #2;
         chk("sw_latency", io_rdata, (k < 10) ? 32'h0 : 32'hC3F0);
      end
      cycle(1'b1, 1'b0, SW_HI_ADDR, 32'h0);
      #2; chk("sw_hi_read", io_rdata, 32'h00A5);

      // Glitch rejection
      sw_val = 24'hA5C3F1;
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, SW_LO_ADDR, 32'h0);
      sw_val = 24'hA5C3F0;
      for (int k = 0; k < 15; k++) begin
         cycle(1'b1, 1'b0, SW_LO_ADDR, 32'h0);
         #2; chk("sw_glitch", io_rdata, 32'hC3F0);
      end

      // Clean button press, then clear-on-read
      btn_val = 1'b1; idle(20);
      btn_val = 1'b0; idle(14);
      cycle(1'b1, 1'b0, BTN_ADDR, 32'h0);
      #2; chk("btn_flag_set", io_rdata, 32'h1);
      cycle(1'b1, 1'b0, BTN_ADDR, 32'h0);
      #2; chk("btn_flag_cleared", io_rdata, 32'h0);

      // Read coinciding with a commit: pre-edge value returned, set wins
      btn_val = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (btn_commit_now()) begin
            cycle(1'b1, 1'b0, BTN_ADDR, 32'h0);
            #2; chk("btn_coincident_read", io_rdata, 32'h0);
            found = 1'b1;
         end else begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      if (!found) chk("btn_commit_reached", 32'h0, 32'h1);
      cycle(1'b1, 1'b0, BTN_ADDR, 32'h0);
      #2; chk("btn_set_wins", io_rdata, 32'h1);
      btn_val = 1'b0; idle(14);

      // Same-cycle read and write
      cycle(1'b0, 1'b1, LED_LO_ADDR, 32'h0011);
      cycle(1'b0, 1'b1, LED_HI_ADDR, 32'h0000);
      cycle(1'b1, 1'b1, LED_LO_ADDR, 32'h2222);
      #2; chk("rw_same_cycle_rdata", io_rdata, 32'h0011);
      @(posedge clk); #1; chk("rw_same_cycle_led", led_pin, 32'h002222);

      // Randomised traffic
      sw_hold = 0; btn_hold = 0;
      for (int n = 0; n < 900; n++) begin
         if (sw_hold == 0) begin
            if ($urandom_range(0, 2) == 0) sw_val = 24'($urandom);
            else sw_val = sw_val ^ (24'd1 << $urandom_range(0, 23));
            sw_hold = $urandom_range(1, 14);
         end
         sw_hold--;
         if (btn_hold == 0) begin
            btn_val = ~btn_val;
            btn_hold = $urandom_range(1, 14);
         end
         btn_hold--;
         op = $urandom_range(0, 3);
         cycle(op[0], op[1], addrs[$urandom_range(0, 8)], $urandom);
      end

      // Reset mid-operation with state populated
      btn_val = 1'b1; idle(14);
      cycle(1'b0, 1'b1, LED_LO_ADDR, 32'hABCD);
      sw_val = 24'hFFFFFF;
      idle(2);
      do_reset();
      cycle(1'b1, 1'b0, SW_LO_ADDR, 32'h0);
      #2; chk("post_reset_sw_read", io_rdata, 32'h0);
      for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, SW_LO_ADDR, 32'h0);
      #2; chk("post_reset_redebounce", io_rdata, 32'hFFFF);
      btn_val = 1'b0;
      idle(4);

      @(posedge clk);
      mon_en = 1'b0;
      if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
